// File: rtl/flag_jump_pc_pkg.sv
// Shared encodings for the flag/jump/PC block: FSM states, jump-bit layout
// and the Hack jump-condition function.
package flag_jump_pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int unsigned JB_W  = 3;
  localparam int unsigned JB_LT = 2;
  localparam int unsigned JB_EQ = 1;
  localparam int unsigned JB_GT = 0;

  // Hack jump: lt on negative, eq on zero, gt on strictly positive
  function automatic logic eval_cond(input logic [JB_W-1:0] jb, input logic z, input logic n);
    return (jb[JB_LT] & n) | (jb[JB_EQ] & z) | (jb[JB_GT] & ~z & ~n);
  endfunction

endpackage

// File: rtl/flag_jump_pc_jump_cond.sv
// Combinational jump-condition decode from jump bits and zero/negative flags.
module jump_cond
  import flag_jump_pc_pkg::*;
(
  input  logic [JB_W-1:0] i_jump_bits,
  input  logic            i_zr,
  input  logic            i_ng,
  output logic            o_cond_c
);

  assign o_cond_c = eval_cond(i_jump_bits, i_zr, i_ng);

endmodule

// File: rtl/flag_jump_pc.sv
// Flag register, jump evaluation, program counter with post-jump bubble and
// saturating taken-jump counter.
module flag_jump_pc
  import flag_jump_pc_pkg::*;
#(
  parameter int unsigned      WIDTH      = 16,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             zr,
  input  logic             ng,
  input  logic             flag_we,
  input  logic             instr_valid,
  input  logic             is_c_instr,
  input  logic [JB_W-1:0]  jump_bits,
  input  logic [WIDTH-1:0] target,
  input  logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             flag_zr,
  output logic             flag_ng,
  output logic             jump_taken,
  output logic [WIDTH-1:0] jump_count
);

  state_e           r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_pc_valid;
  logic             r_flag_zr;
  logic             r_flag_ng;
  logic             r_jump_taken;
  logic [WIDTH-1:0] r_count;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_pc_nxt;
  logic             w_jt_nxt;
  logic             w_take;
  logic             w_ezr;
  logic             w_eng;
  logic             w_cond;
  logic [WIDTH-1:0] w_count_nxt;

  // Same-cycle bypass so a jump can act on the flags being written now
  assign w_ezr = flag_we ? zr : r_flag_zr;
  assign w_eng = flag_we ? ng : r_flag_ng;

  jump_cond u_jump_cond (
    .i_jump_bits (jump_bits),
    .i_zr        (w_ezr),
    .i_ng        (w_eng),
    .o_cond_c    (w_cond)
  );

  // Next-state, next-pc and jump decision; stall freezes everything
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_jt_nxt    = 1'b0;
    w_take      = 1'b0;
    if (!stall) begin
      case (r_state)
        ST_BOOT:  w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (instr_valid && is_c_instr && w_cond) begin
            w_take      = 1'b1;
            w_jt_nxt    = 1'b1;
            w_pc_nxt    = target;
            w_state_nxt = ST_FLUSH;
          end else if (instr_valid) begin
            w_pc_nxt = r_pc + WIDTH'(1);
          end
        end
        ST_FLUSH: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_BOOT;
      endcase
    end
  end

  assign w_count_nxt = (w_take && (r_count != '1)) ? r_count + WIDTH'(1) : r_count;

  // State register and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_ADDR;
      r_pc_valid   <= 1'b0;
      r_flag_zr    <= 1'b0;
      r_flag_ng    <= 1'b0;
      r_jump_taken <= 1'b0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pc_valid   <= (w_state_nxt == ST_RUN);
      r_jump_taken <= w_jt_nxt;
      r_count      <= w_count_nxt;
      if (flag_we && !stall) begin
        r_flag_zr <= zr;
        r_flag_ng <= ng;
      end
    end
  end

  assign pc         = r_pc;
  assign pc_valid   = r_pc_valid;
  assign flag_zr    = r_flag_zr;
  assign flag_ng    = r_flag_ng;
  assign jump_taken = r_jump_taken;
  assign jump_count = r_count;

endmodule
